usbdev_iomux_filt: RTL and testbench

USBDEV_IOMUX_FILT -- requirements
Module: usbdev_iomux_filt

---
 rtl/usbdev_iomux_filt.sv | 127 ++++++++++++
 tb/tb_usbdev_iomux_filt.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/usbdev_iomux_filt.sv
// USB device I/O front end: input synchronizers, receive glitch filter,
// VBUS sense debounce with edge pulses, and a packet-safe tx/ctl override mux.
module usbdev_iomux_filt #(
  parameter int unsigned SyncStages = 2,
  parameter int unsigned NumRx      = 3,
  parameter int unsigned FiltW      = 4,
  parameter int unsigned DebW       = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [NumRx-1:0] rx_i,
  input  logic             sense_i,
  input  logic             filt_en_i,
  input  logic [FiltW-1:0] filt_thresh_i,
  input  logic [DebW-1:0]  deb_thresh_i,
  output logic [NumRx-1:0] rx_o,
  output logic             sense_o,
  output logic             sense_rise_o,
  output logic             sense_fall_o,
  input  logic [4:0]       core_tx_i,
  input  logic [4:0]       ovr_tx_i,
  input  logic [2:0]       core_ctl_i,
  input  logic [2:0]       ovr_ctl_i,
  input  logic             ovr_en_i,
  output logic [4:0]       tx_o,
  output logic [2:0]       ctl_o,
  output logic             ovr_active_o
);

  localparam int unsigned OeBit = 4;

  logic [SyncStages-1:0][NumRx-1:0] rx_sync;
  logic [SyncStages-1:0]            sense_sync;
  logic [NumRx-1:0]                 rx_s;
  logic                             sense_s;

  logic [NumRx-1:0][FiltW-1:0]      filt_cnt, filt_cnt_d;
  logic [NumRx-1:0]                 rx_d;
  logic [DebW-1:0]                  deb_cnt, deb_cnt_d;
  logic                             sense_upd;

  logic                             sel_q;
  logic                             cur_oe;

  // Synchronizer chains; the last stage is the synced value.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_sync    <= '0;
      sense_sync <= '0;
    end else begin
      rx_sync    <= {rx_sync[SyncStages-2:0], rx_i};
      sense_sync <= {sense_sync[SyncStages-2:0], sense_i};
    end
  end

  assign rx_s    = rx_sync[SyncStages-1];
  assign sense_s = sense_sync[SyncStages-1];

  // Per-bit glitch filter: a differing value must persist until the count reaches threshold.
  always_comb begin
    rx_d       = rx_o;
    filt_cnt_d = filt_cnt;
    for (int unsigned i = 0; i < NumRx; i++) begin
      if (!filt_en_i) begin
        rx_d[i]       = rx_s[i];
        filt_cnt_d[i] = '0;
      end else if (rx_s[i] == rx_o[i]) begin
        filt_cnt_d[i] = '0;
      end else if (filt_cnt[i] >= filt_thresh_i) begin
        rx_d[i]       = rx_s[i];
        filt_cnt_d[i] = '0;
      end else if (filt_cnt[i] != '1) begin
        filt_cnt_d[i] = filt_cnt[i] + FiltW'(1);
      end
    end
  end

  // Sense debounce, always active, same counting scheme as the rx filter.
  always_comb begin
    deb_cnt_d = deb_cnt;
    sense_upd = 1'b0;
    if (sense_s == sense_o) begin
      deb_cnt_d = '0;
    end else if (deb_cnt >= deb_thresh_i) begin
      sense_upd = 1'b1;
      deb_cnt_d = '0;
    end else if (deb_cnt != '1) begin
      deb_cnt_d = deb_cnt + DebW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_o         <= '0;
      filt_cnt     <= '0;
      sense_o      <= 1'b0;
      deb_cnt      <= '0;
      sense_rise_o <= 1'b0;
      sense_fall_o <= 1'b0;
    end else begin
      rx_o         <= rx_d;
      filt_cnt     <= filt_cnt_d;
      deb_cnt      <= deb_cnt_d;
      sense_rise_o <= sense_upd & sense_s;
      sense_fall_o <= sense_upd & ~sense_s;
      if (sense_upd) begin
        sense_o <= sense_s;
      end
    end
  end

  // Selection only hands over while the currently driving source is idle (oe low).
  assign cur_oe = sel_q ? ovr_tx_i[OeBit] : core_tx_i[OeBit];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sel_q <= 1'b0;
    end else if ((ovr_en_i != sel_q) && !cur_oe) begin
      sel_q <= ovr_en_i;
    end
  end

  assign tx_o         = sel_q ? ovr_tx_i : core_tx_i;
  assign ctl_o        = sel_q ? ovr_ctl_i : core_ctl_i;
  assign ovr_active_o = sel_q;

endmodule

// File: tb/tb_usbdev_iomux_filt.sv
// Directed self-checking bench for usbdev_iomux_filt (three-stage synchronizers).
module tb_usbdev_iomux_filt;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic [2:0] rx_i;
  logic       sense_i;
  logic       filt_en_i;
  logic [3:0] filt_thresh_i;
  logic [15:0] deb_thresh_i;
  logic [2:0] rx_o;
  logic       sense_o, sense_rise_o, sense_fall_o;
  logic [4:0] core_tx_i, ovr_tx_i, tx_o;
  logic [2:0] core_ctl_i, ovr_ctl_i, ctl_o;
  logic       ovr_en_i, ovr_active_o;

  int errors = 0;
  int checks = 0;
  int rise_cnt = 0;
  int fall_cnt = 0;
  int r0, f0;
  logic bad;

  always #5 clk_i = ~clk_i;

  usbdev_iomux_filt #(.SyncStages(3), .NumRx(3), .FiltW(4), .DebW(16)) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .rx_i          (rx_i),
    .sense_i       (sense_i),
    .filt_en_i     (filt_en_i),
    .filt_thresh_i (filt_thresh_i),
    .deb_thresh_i  (deb_thresh_i),
    .rx_o          (rx_o),
    .sense_o       (sense_o),
    .sense_rise_o  (sense_rise_o),
    .sense_fall_o  (sense_fall_o),
    .core_tx_i     (core_tx_i),
    .ovr_tx_i      (ovr_tx_i),
    .core_ctl_i    (core_ctl_i),
    .ovr_ctl_i     (ovr_ctl_i),
    .ovr_en_i      (ovr_en_i),
    .tx_o          (tx_o),
    .ctl_o         (ctl_o),
    .ovr_active_o  (ovr_active_o)
  );

  // Edge-pulse tally, sampled away from the active edge.
  always @(negedge clk_i) begin
    if (sense_rise_o) rise_cnt++;
    if (sense_fall_o) fall_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_ni        = 1'b0;
    rx_i          = 3'b000;
    sense_i       = 1'b0;
    filt_en_i     = 1'b0;
    filt_thresh_i = 4'd3;
    deb_thresh_i  = 16'd10;
    core_tx_i     = 5'h0A;
    ovr_tx_i      = 5'h15;
    core_ctl_i    = 3'b101;
    ovr_ctl_i     = 3'b010;
    ovr_en_i      = 1'b0;
    step(3);

    // Reset state
    chk("rst_rx_o",   32'(rx_o), 32'h0);
    chk("rst_sense",  32'(sense_o), 32'h0);
    chk("rst_rise",   32'(sense_rise_o), 32'h0);
    chk("rst_fall",   32'(sense_fall_o), 32'h0);
    chk("rst_active", 32'(ovr_active_o), 32'h0);
    chk("rst_tx",     32'(tx_o), 32'h0A);
    chk("rst_ctl",    32'(ctl_o), 32'h5);
    rst_ni = 1'b1;
    step(2);

    // Unfiltered: SyncStages+1 = 4 cycles latency
    rx_i = 3'b101;
    step(3);
    chk("unf_rise_early", 32'(rx_o), 32'h0);
    step(1);
    chk("unf_rise", 32'(rx_o), 32'h5);
    rx_i = 3'b000;
    step(3);
    chk("unf_fall_early", 32'(rx_o), 32'h5);
    step(1);
    chk("unf_fall", 32'(rx_o), 32'h0);

    // Filtered, thresh 3: 2-cycle pulse rejected
    filt_en_i     = 1'b1;
    filt_thresh_i = 4'd3;
    rx_i = 3'b001;
    step(2);
    rx_i = 3'b000;
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      bad = bad | rx_o[0];
    end
    chk("filt_glitch_rejected", 32'(bad), 32'h0);

    // Held input passes after SyncStages+4 = 7 cycles
    rx_i = 3'b001;
    step(6);
    chk("filt_hold_early", 32'(rx_o), 32'h0);
    step(1);
    chk("filt_hold_rise", 32'(rx_o), 32'h1);
    rx_i = 3'b000;
    step(6);
    chk("filt_fall_early", 32'(rx_o), 32'h1);
    step(1);
    chk("filt_fall", 32'(rx_o), 32'h0);

    // Threshold 0 behaves like the unfiltered path
    filt_thresh_i = 4'd0;
    rx_i = 3'b010;
    step(3);
    chk("thr0_early", 32'(rx_o), 32'h0);
    step(1);
    chk("thr0_rise", 32'(rx_o), 32'h2);
    rx_i = 3'b000;
    step(4);
    chk("thr0_fall", 32'(rx_o), 32'h0);

    // Live threshold lowered mid-count
    filt_thresh_i = 4'd8;
    rx_i = 3'b100;
    step(6);
    chk("live_thr_early", 32'(rx_o), 32'h0);
    chk("live_thr_cnt", 32'(dut.filt_cnt), 32'(12'h300));
    filt_thresh_i = 4'd2;
    step(1);
    chk("live_thr_rise", 32'(rx_o), 32'h4);
    chk("live_thr_cnt_clr", 32'(dut.filt_cnt), 32'h0);
    rx_i = 3'b000;
    filt_thresh_i = 4'd0;
    step(4);
    chk("live_thr_fall", 32'(rx_o), 32'h0);

    // Debounce with a one-cycle low glitch at cycle 6
    sense_i = 1'b1;
    step(5);
    sense_i = 1'b0;
    step(1);
    sense_i = 1'b1;
    r0 = rise_cnt;
    step(13);
    chk("deb_early", 32'(sense_o), 32'h0);
    chk("deb_no_early_rise", 32'(rise_cnt - r0), 32'h0);
    step(1);
    chk("deb_rise", 32'(sense_o), 32'h1);
    chk("deb_rise_pulse", 32'(sense_rise_o), 32'h1);
    chk("deb_no_fall", 32'(sense_fall_o), 32'h0);
    step(3);
    chk("deb_pulse_count", 32'(rise_cnt - r0), 32'h1);
    chk("deb_pulse_gone", 32'(sense_rise_o), 32'h0);

    // Reset in the middle of a falling debounce
    sense_i = 1'b0;
    step(5);
    chk("mid_deb_cnt", 32'(dut.deb_cnt), 32'h2);
    f0 = fall_cnt;
    rst_ni = 1'b0;
    sense_i = 1'b1;
    #1;
    chk("rstmid_sense", 32'(sense_o), 32'h0);
    chk("rstmid_fall", 32'(sense_fall_o), 32'h0);
    chk("rstmid_deb_cnt", 32'(dut.deb_cnt), 32'h0);
    chk("rstmid_filt_cnt", 32'(dut.filt_cnt), 32'h0);
    step(2);
    rst_ni = 1'b1;
    step(13);
    chk("post_rst_early", 32'(sense_o), 32'h0);
    chk("post_rst_no_fall", 32'(fall_cnt - f0), 32'h0);
    step(1);
    chk("post_rst_rise", 32'(sense_o), 32'h1);
    chk("post_rst_rise_pulse", 32'(sense_rise_o), 32'h1);

    // Override request while core is mid-packet
    core_tx_i = 5'b10101;
    ovr_tx_i  = 5'b01010;
    ovr_en_i  = 1'b1;
    step(3);
    chk("ovr_wait_active", 32'(ovr_active_o), 32'h0);
    chk("ovr_wait_tx", 32'(tx_o), 32'h15);
    core_tx_i = 5'b00101;
    #1;
    chk("ovr_idle_tx_core", 32'(tx_o), 32'h05);
    step(1);
    chk("ovr_taken", 32'(ovr_active_o), 32'h1);
    chk("ovr_tx", 32'(tx_o), 32'h0A);
    chk("ovr_ctl", 32'(ctl_o), 32'h2);

    // Release while override is mid-packet
    ovr_tx_i = 5'b11010;
    ovr_en_i = 1'b0;
    step(3);
    chk("rel_held", 32'(ovr_active_o), 32'h1);
    chk("rel_held_tx", 32'(tx_o), 32'h1A);
    ovr_tx_i = 5'b01010;
    step(1);
    chk("rel_done", 32'(ovr_active_o), 32'h0);
    chk("rel_tx", 32'(tx_o), 32'h05);
    chk("rel_ctl", 32'(ctl_o), 32'h5);

    // Request withdrawn before handover is dropped
    core_tx_i = 5'b10101;
    ovr_en_i  = 1'b1;
    step(2);
    ovr_en_i  = 1'b0;
    core_tx_i = 5'b00101;
    step(2);
    chk("withdrawn", 32'(ovr_active_o), 32'h0);

    // Reset drops the selection
    ovr_en_i = 1'b1;
    step(1);
    chk("sel_before_rst", 32'(ovr_active_o), 32'h1);
    rst_ni = 1'b0;
    #1;
    chk("sel_rst", 32'(ovr_active_o), 32'h0);
    chk("sel_rst_tx", 32'(tx_o), 32'h05);
    step(1);
    rst_ni = 1'b1;
    step(1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
